// File: rtl/tagger_tab_commit_ctrl.sv
// tagger_tab_commit_ctrl: atomic, drain-safe commit of partition tagging tables
// from configuration registers into the tagger datapath.
// Optional feature macro: TAGGER_TAB_ORDER_CHECK_EN (adds the CHECK state that
// rejects tables whose base addresses are not strictly increasing).
//
// state | meaning
// IDLE  | waiting for commit_i; active table stable
// CHECK | walking shadow addresses, one adjacent pair per cycle
// DRAIN | quiesce_req_o high, waiting for quiesced_i or drain timeout
// SWAP  | quiesce still held; shadow copied to active on the exit edge
module tagger_tab_commit_ctrl #(
  parameter int unsigned MAXPARTITION  = 4,
  parameter int unsigned PATID_LEN     = 8,
  parameter int unsigned CONF_LEN      = 2,
  parameter int unsigned REG_ADDR_LEN  = 32,
  parameter int unsigned DRAIN_TIMEOUT = 1024
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [MAXPARTITION*REG_ADDR_LEN-1:0]     cfg_addr_i,
  input  logic [MAXPARTITION*PATID_LEN-1:0]        cfg_patid_i,
  input  logic [MAXPARTITION*CONF_LEN-1:0]         cfg_conf_i,
  input  logic                                     commit_i,
  output logic                                     commit_clr_o,
  output logic                                     quiesce_req_o,
  input  logic                                     quiesced_i,
  output logic [MAXPARTITION*(REG_ADDR_LEN+2)-1:0] tab_addr_o,
  output logic [MAXPARTITION*PATID_LEN-1:0]        tab_patid_o,
  output logic [MAXPARTITION*CONF_LEN-1:0]         tab_conf_o,
  output logic                                     tab_valid_o,
  output logic                                     busy_o,
  output logic [1:0]                               err_o,
  output logic [7:0]                               gen_o
);

  // A zero timeout means wait forever; keep a 1-bit counter so widths stay legal.
  localparam int unsigned   CNT_W    = (DRAIN_TIMEOUT > 0) ? $clog2(DRAIN_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DRAIN_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

`ifdef TAGGER_TAB_ORDER_CHECK_EN
  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_DRAIN, ST_SWAP} state_e;
  localparam int unsigned IDX_W = (MAXPARTITION > 1) ? $clog2(MAXPARTITION) : 1;
  logic [IDX_W-1:0] chk_idx_q;
  logic             chk_inc;
  logic             set_err_ord;
  logic             err_ord_q;
  logic             addr_bad;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_SWAP} state_e;
`endif

  state_e state_q, state_d;

  logic [REG_ADDR_LEN-1:0] shd_addr_q  [MAXPARTITION];
  logic [PATID_LEN-1:0]    shd_patid_q [MAXPARTITION];
  logic [CONF_LEN-1:0]     shd_conf_q  [MAXPARTITION];
  logic [REG_ADDR_LEN-1:0] act_addr_q  [MAXPARTITION];
  logic [PATID_LEN-1:0]    act_patid_q [MAXPARTITION];
  logic [CONF_LEN-1:0]     act_conf_q  [MAXPARTITION];

  logic             tab_valid_q;
  logic [7:0]       gen_q;
  logic             err_to_q;
  logic [CNT_W-1:0] cnt_q;
  logic             snap, swap, set_err_to, timeout_hit;

  assign timeout_hit = (DRAIN_TIMEOUT != 0) && (cnt_q == CNT_LAST);

`ifdef TAGGER_TAB_ORDER_CHECK_EN
  assign addr_bad = (shd_addr_q[chk_idx_q] <= shd_addr_q[chk_idx_q - 1'b1]);
`endif

  // Next-state and control decode; quiesced_i wins over a same-cycle timeout.
  always_comb begin
    state_d      = state_q;
    commit_clr_o = 1'b0;
    snap         = 1'b0;
    swap         = 1'b0;
    set_err_to   = 1'b0;
`ifdef TAGGER_TAB_ORDER_CHECK_EN
    chk_inc      = 1'b0;
    set_err_ord  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (commit_i) begin
          commit_clr_o = 1'b1;
          snap         = 1'b1;
`ifdef TAGGER_TAB_ORDER_CHECK_EN
          state_d      = (MAXPARTITION > 1) ? ST_CHECK : ST_DRAIN;
`else
          state_d      = ST_DRAIN;
`endif
        end
      end
`ifdef TAGGER_TAB_ORDER_CHECK_EN
      ST_CHECK: begin
        if (addr_bad) begin
          set_err_ord = 1'b1;
          state_d     = ST_IDLE;
        end else if (chk_idx_q == IDX_W'(MAXPARTITION - 1)) begin
          state_d     = ST_DRAIN;
        end else begin
          chk_inc     = 1'b1;
        end
      end
`endif
      ST_DRAIN: begin
        if (quiesced_i) begin
          state_d = ST_SWAP;
        end else if (timeout_hit) begin
          set_err_to = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_SWAP: begin
        swap    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Shadow table captures cfg_* once, at commit acceptance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < int'(MAXPARTITION); k++) begin
        shd_addr_q[k]  <= '0;
        shd_patid_q[k] <= '0;
        shd_conf_q[k]  <= '0;
      end
    end else if (snap) begin
      for (int k = 0; k < int'(MAXPARTITION); k++) begin
        shd_addr_q[k]  <= cfg_addr_i[k*REG_ADDR_LEN +: REG_ADDR_LEN];
        shd_patid_q[k] <= cfg_patid_i[k*PATID_LEN +: PATID_LEN];
        shd_conf_q[k]  <= cfg_conf_i[k*CONF_LEN +: CONF_LEN];
      end
    end
  end

  // Active table, generation and valid flag change together on the SWAP exit edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < int'(MAXPARTITION); k++) begin
        act_addr_q[k]  <= '0;
        act_patid_q[k] <= '0;
        act_conf_q[k]  <= '0;
      end
      gen_q       <= 8'd0;
      tab_valid_q <= 1'b0;
    end else if (swap) begin
      for (int k = 0; k < int'(MAXPARTITION); k++) begin
        act_addr_q[k]  <= shd_addr_q[k];
        act_patid_q[k] <= shd_patid_q[k];
        act_conf_q[k]  <= shd_conf_q[k];
      end
      gen_q       <= gen_q + 8'd1;
      tab_valid_q <= 1'b1;
    end
  end

  // Drain cycle counter: zero outside DRAIN, saturates at the timeout value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                   cnt_q <= '0;
    else if (state_q != ST_DRAIN)  cnt_q <= '0;
    else if (cnt_q != CNT_MAX)     cnt_q <= cnt_q + 1'b1;
  end

  // Sticky drain-timeout flag, cleared when a new commit is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)         err_to_q <= 1'b0;
    else if (snap)       err_to_q <= 1'b0;
    else if (set_err_to) err_to_q <= 1'b1;
  end

`ifdef TAGGER_TAB_ORDER_CHECK_EN
  // Order-check index and sticky order-violation flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chk_idx_q <= '0;
      err_ord_q <= 1'b0;
    end else begin
      if (snap)         chk_idx_q <= IDX_W'(1);
      else if (chk_inc) chk_idx_q <= chk_idx_q + 1'b1;
      if (snap)             err_ord_q <= 1'b0;
      else if (set_err_ord) err_ord_q <= 1'b1;
    end
  end
  assign err_o = {err_ord_q, err_to_q};
`else
  assign err_o = {1'b0, err_to_q};
`endif

  for (genvar k = 0; k < MAXPARTITION; k++) begin : g_out
    assign tab_addr_o[k*(REG_ADDR_LEN+2) +: REG_ADDR_LEN+2] = {act_addr_q[k], 2'b00};
    assign tab_patid_o[k*PATID_LEN +: PATID_LEN]           = act_patid_q[k];
    assign tab_conf_o[k*CONF_LEN +: CONF_LEN]              = act_conf_q[k];
  end

  assign quiesce_req_o = (state_q == ST_DRAIN) || (state_q == ST_SWAP);
  assign busy_o        = (state_q != ST_IDLE);
  assign tab_valid_o   = tab_valid_q;
  assign gen_o         = gen_q;

endmodule

// File: tb/tb_tagger_tab_commit_ctrl.sv
// Self-checking bench for tagger_tab_commit_ctrl: vector table with a
// scoreboard queue, plus hand-written re-commit, reset and wrap sequences.
`timescale 1ns/1ps
module tb_tagger_tab_commit_ctrl;
  localparam int NP = 4, PW = 8, CW = 2, AW = 32, TO = 16;
`ifdef TAGGER_TAB_ORDER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int BASE_LAT = CHK ? NP + 2 : 3;

  logic                   clk_i = 1'b0;
  logic                   rst_ni = 1'b1;
  logic [NP*AW-1:0]       cfg_addr_i = '0;
  logic [NP*PW-1:0]       cfg_patid_i = '0;
  logic [NP*CW-1:0]       cfg_conf_i = '0;
  logic                   commit_i = 1'b0;
  logic                   quiesced_i = 1'b0;
  logic                   commit_clr_o, quiesce_req_o, tab_valid_o, busy_o;
  logic [NP*(AW+2)-1:0]   tab_addr_o;
  logic [NP*PW-1:0]       tab_patid_o;
  logic [NP*CW-1:0]       tab_conf_o;
  logic [1:0]             err_o;
  logic [7:0]             gen_o;

  tagger_tab_commit_ctrl #(
    .MAXPARTITION(NP), .PATID_LEN(PW), .CONF_LEN(CW),
    .REG_ADDR_LEN(AW), .DRAIN_TIMEOUT(TO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_addr_i(cfg_addr_i), .cfg_patid_i(cfg_patid_i), .cfg_conf_i(cfg_conf_i),
    .commit_i(commit_i), .commit_clr_o(commit_clr_o),
    .quiesce_req_o(quiesce_req_o), .quiesced_i(quiesced_i),
    .tab_addr_o(tab_addr_o), .tab_patid_o(tab_patid_o), .tab_conf_o(tab_conf_o),
    .tab_valid_o(tab_valid_o), .busy_o(busy_o), .err_o(err_o), .gen_o(gen_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [NP*AW-1:0] addr;
    logic [NP*PW-1:0] patid;
    logic [NP*CW-1:0] conf;
    int               qd;
  } vec_t;

  typedef struct {
    logic [NP*(AW+2)-1:0] addr;
    logic [NP*PW-1:0]     patid;
    logic [NP*CW-1:0]     conf;
    logic [7:0]           gen;
    logic                 valid;
    logic [1:0]           err;
    int                   lat;
  } exp_t;

  exp_t sbq[$];
  vec_t vt[8];

  int n_pass = 0, n_total = 0;

  // Reference model of the active table.
  logic [NP*AW-1:0] m_addr = '0;
  logic [NP*PW-1:0] m_patid = '0;
  logic [NP*CW-1:0] m_conf = '0;
  logic [7:0]       m_gen = '0;
  logic             m_valid = 1'b0;

  // Datapath model: refuses quiescence for the first q_delay DRAIN cycles.
  int q_delay = 0;
  int drain_cyc = 0;
  bit saw_q = 1'b0;
  always @(negedge clk_i) begin
    if (quiesce_req_o) begin
      drain_cyc = drain_cyc + 1;
      saw_q = 1'b1;
    end else begin
      drain_cyc = 0;
    end
    quiesced_i = quiesce_req_o && (drain_cyc > q_delay);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  function automatic logic [NP*AW-1:0] pa(input logic [AW-1:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [NP*(AW+2)-1:0] to_byte(input logic [NP*AW-1:0] a);
    logic [NP*(AW+2)-1:0] r;
    for (int k = 0; k < NP; k++) r[k*(AW+2) +: AW+2] = {a[k*AW +: AW], 2'b00};
    return r;
  endfunction

  task automatic drive(input vec_t v);
    cfg_addr_i  = v.addr;
    cfg_patid_i = v.patid;
    cfg_conf_i  = v.conf;
    q_delay     = v.qd;
  endtask

  // Push the expected outcome of committing v and advance the model.
  task automatic predict(input vec_t v);
    exp_t e;
    bit   bad = 1'b0;
    if (CHK) begin
      for (int k = 1; k < NP; k++)
        if (v.addr[k*AW +: AW] <= v.addr[(k-1)*AW +: AW]) bad = 1'b1;
    end
    e.lat = -1;
    if (bad) e.err = 2'b10;
    else if (v.qd >= TO) e.err = 2'b01;
    else begin
      m_addr  = v.addr;
      m_patid = v.patid;
      m_conf  = v.conf;
      m_gen   = m_gen + 8'd1;
      m_valid = 1'b1;
      e.err   = 2'b00;
      e.lat   = BASE_LAT + v.qd;
    end
    e.addr  = to_byte(m_addr);
    e.patid = m_patid;
    e.conf  = m_conf;
    e.gen   = m_gen;
    e.valid = m_valid;
    sbq.push_back(e);
  endtask

  task automatic cmp_tab(input string nm, input exp_t e);
    check({nm, " tab_addr"}, tab_addr_o, e.addr);
    check({nm, " tab_patid"}, tab_patid_o, e.patid);
    check({nm, " tab_conf"}, tab_conf_o, e.conf);
    check({nm, " gen"}, gen_o, e.gen);
    check({nm, " valid"}, tab_valid_o, e.valid);
    check({nm, " err"}, err_o, e.err);
  endtask

  task automatic wait_idle(input string nm, input logic [7:0] g0, output int lat);
    int cyc = 1;
    lat = -1;
    while (busy_o && cyc < 200) begin
      @(posedge clk_i); #1;
      cyc++;
      if (lat < 0 && gen_o != g0) lat = cyc;
    end
    if (busy_o) check({nm, " return to idle"}, busy_o, 1'b0);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    exp_t       e;
    int         lat;
    logic [7:0] g0;
    @(negedge clk_i);
    drive(v);
    predict(v);
    g0 = gen_o;
    commit_i = 1'b1;
    #1;
    check({nm, " commit_clr"}, commit_clr_o, 1'b1);
    @(posedge clk_i); #1;
    saw_q = 1'b0;
    commit_i = 1'b0;
    lat = (gen_o != g0) ? 1 : -1;
    if (lat < 0) wait_idle(nm, g0, lat);
    e = sbq.pop_front();
    cmp_tab(nm, e);
    check({nm, " latency"}, lat, e.lat);
    check({nm, " quiesce seen"}, saw_q, (e.err != 2'b10));
    check({nm, " quiesce off"}, quiesce_req_o, 1'b0);
  endtask

  task automatic quick_commit();
    int n = 0;
    @(negedge clk_i);
    commit_i = 1'b1;
    @(posedge clk_i); #1;
    commit_i = 1'b0;
    while (busy_o && n < 100) begin @(posedge clk_i); #1; n++; end
    if (busy_o) check("quick commit idle", busy_o, 1'b0);
  endtask

  initial begin
    exp_t e;
    vec_t va, vb, vc;
    bit   clr_bad;
    int   n;

    vt[0] = '{pa(32'h100, 32'h200, 32'h300, 32'h400), 32'h44332211, 8'b11100100, 0};
    vt[1] = '{pa(32'h100, 32'h300, 32'h200, 32'h400), 32'hAABBCCDD, 8'b01010101, 0};
    vt[2] = '{pa(32'h10, 32'h20, 32'h30, 32'h40), 32'h0F0E0D0C, 8'b10101010, 12};
    vt[3] = '{pa(32'h11, 32'h22, 32'h33, 32'h44), 32'h12345678, 8'b00011011, 16};
    vt[4] = '{pa(32'h21, 32'h32, 32'h43, 32'h54), 32'h87654321, 8'b11011000, 15};
    vt[5] = '{pa(32'h50, 32'h50, 32'h60, 32'h70), 32'h01020304, 8'b00110011, 0};
    vt[6] = '{pa(32'h0, 32'h1, 32'hFFFF_FFFE, 32'hFFFF_FFFF), 32'hFFEEDDCC, 8'b11111111, 3};
    vt[7] = '{pa(32'h1, 32'h2, 32'h3, 32'h3), 32'h5A5A5A5A, 8'b10000001, 0};

    #1 rst_ni = 1'b0;
    #1;
    check("reset tab_addr", tab_addr_o, '0);
    check("reset tab_patid", tab_patid_o, '0);
    check("reset tab_conf", tab_conf_o, '0);
    check("reset valid", tab_valid_o, 1'b0);
    check("reset busy", busy_o, 1'b0);
    check("reset err", err_o, 2'b00);
    check("reset gen", gen_o, 8'd0);
    check("reset quiesce", quiesce_req_o, 1'b0);
    check("reset commit_clr", commit_clr_o, 1'b0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vt[i], $sformatf("v%0d", i));

    // Re-commit during DRAIN; cfg changed after snapshot.
    va = '{pa(32'h1000, 32'h2000, 32'h3000, 32'h4000), 32'hA1A2A3A4, 8'b01100110, 4};
    vb = '{pa(32'h1004, 32'h2004, 32'h3004, 32'h4004), 32'hB1B2B3B4, 8'b10011001, 4};
    clr_bad = 1'b0;
    @(negedge clk_i);
    drive(va);
    predict(va);
    commit_i = 1'b1;
    #1;
    check("t5 clr first", commit_clr_o, 1'b1);
    @(posedge clk_i); #1;
    commit_i = 1'b0;
    @(negedge clk_i);
    drive(vb);
    n = 0;
    while (!quiesce_req_o && n < 50) begin @(negedge clk_i); n++; end
    check("t5 reached drain", quiesce_req_o, 1'b1);
    commit_i = 1'b1;
    predict(vb);
    n = 0;
    while (busy_o && n < 100) begin
      @(posedge clk_i); #1;
      n++;
      if (busy_o && commit_clr_o) clr_bad = 1'b1;
    end
    check("t5 no clr while busy", clr_bad, 1'b0);
    check("t5 clr on return", commit_clr_o, 1'b1);
    e = sbq.pop_front();
    cmp_tab("t5 first", e);
    @(posedge clk_i); #1;
    commit_i = 1'b0;
    n = 0;
    while (busy_o && n < 100) begin @(posedge clk_i); #1; n++; end
    check("t5 second idle", busy_o, 1'b0);
    e = sbq.pop_front();
    cmp_tab("t5 second", e);

    // Reset in the middle of DRAIN.
    vc = '{pa(32'h7000, 32'h7100, 32'h7200, 32'h7300), 32'hC1C2C3C4, 8'b00001111, 10};
    @(negedge clk_i);
    drive(vc);
    commit_i = 1'b1;
    @(posedge clk_i); #1;
    commit_i = 1'b0;
    n = 0;
    while (!quiesce_req_o && n < 50) begin @(posedge clk_i); #1; n++; end
    check("t6 reached drain", quiesce_req_o, 1'b1);
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("t6 quiesce dropped", quiesce_req_o, 1'b0);
    check("t6 valid cleared", tab_valid_o, 1'b0);
    check("t6 gen cleared", gen_o, 8'd0);
    check("t6 table cleared", tab_addr_o, '0);
    check("t6 busy cleared", busy_o, 1'b0);
    m_addr = '0; m_patid = '0; m_conf = '0; m_gen = 8'd0; m_valid = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Generation counter wrap.
    @(negedge clk_i);
    drive(vt[0]);
    for (int i = 1; i <= 256; i++) begin
      quick_commit();
      if (i == 255) check("gen at 255", gen_o, 8'd255);
    end
    check("gen wrapped", gen_o, 8'd0);
    check("valid after wrap", tab_valid_o, 1'b1);
    check("table after wrap", tab_addr_o, to_byte(vt[0].addr));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
